input_conditioner: RTL and testbench
====================================

INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 100000, meaning the number of consecutive stable synchronized samples required to accept a new level (1 ms at 100 MHz); legal range 2..2^20.
REQ-002 SHALL have ports:
  clk  input  1  system clock, all state on rising edge
  rst  input  1  asynchronous, active-high reset
  sw_raw  input  16  unsynchronized slide-switch pins
  btn_raw  input  4  unsynchronized push-button pins, 1 = pressed
  evt_clr  input  4  per-bit clear of btn_event, sampled each clock
  sw_stable  output  16  debounced switch levels, consumed by the switch/button read register
  btn_stable  output  4  debounced button levels
  btn_press  output  4  one-cycle pulse per debounced button 0->1 transition
  btn_event  output  4  sticky press flags
  change_irq  output  1  one-cycle pulse on any accepted change
REQ-003 SHALL register every output; no combinational path from any input to any output.

Function
REQ-004 Each of the 20 inputs (sw_raw[15:0], btn_raw[3:0]) SHALL pass through its own 2-flop synchronizer; only the second flop (sync) feeds further logic.
REQ-005 Each input SHALL have an independent counter of width ceil(log2(DEBOUNCE_CYCLES)) bits.
REQ-006 On each edge, if sync == stable: counter <= 0, stable unchanged.
REQ-007 On each edge, if sync != stable and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
REQ-008 On each edge, if sync != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync, counter <= 0.
REQ-009 Latency: a raw level established before edge 1 and held SHALL appear on the stable output at edge DEBOUNCE_CYCLES+2, not earlier.
REQ-010 A raw pulse/glitch whose synchronized width is < DEBOUNCE_CYCLES cycles SHALL leave stable unchanged (counter returns to 0 when sync matches stable again).
REQ-011 The counter SHALL never wrap; it saturates only via the accept rule of REQ-008.
REQ-012 btn_press[i] SHALL be 1 for exactly the one cycle after the edge where btn_stable[i] goes 0->1; no pulse on 1->0.
REQ-013 btn_event[i] SHALL set when btn_press[i] is 1 and clear when evt_clr[i] is 1; when both occur in the same cycle, set wins.
REQ-014 change_irq SHALL be 1 for exactly one cycle following any edge on which any sw_stable bit changes (either direction) or any btn_press bit is asserted; simultaneous changes produce a single pulse.
REQ-015 Inputs SHALL be processed independently; simultaneous transitions on several inputs SHALL each follow REQ-006..REQ-008 with no interaction.

Reset
REQ-016 While rst=1: synchronizer flops, counters, sw_stable, btn_stable, btn_press, btn_event and change_irq SHALL all be 0, asynchronously.
REQ-017 After rst deasserts, an input already held at 1 SHALL be accepted per REQ-009 counting from the first edge after release, producing btn_press/change_irq pulses as a normal 0->1 transition.
REQ-018 Reset asserted mid-debounce SHALL discard the partial count; no stale acceptance after release.

Verification (DEBOUNCE_CYCLES=4)
REQ-019 sw_raw 0x0000->0xA5A5 just before edge 1, held -> sw_stable stays 0x0000 through edge 5, becomes 0xA5A5 at edge 6; change_irq high one cycle after edge 6.
REQ-020 btn_raw[2] high for 3 cycles then low -> btn_stable, btn_press, btn_event, change_irq stay 0 throughout.
REQ-021 btn_raw[0] held high -> btn_stable[0]=1 at edge 6, btn_press[0] one-cycle pulse, btn_event[0]=1 persistently; release and re-debounce low -> no btn_press, btn_event[0] still 1.
REQ-022 btn_event[1]=1, then evt_clr[1]=1 in the same cycle as a new btn_press[1] -> btn_event[1] remains 1; evt_clr[1] alone next cycle -> btn_event[1]=0.
REQ-023 btn_raw=4'hF held, rst pulsed at edge 4 of debounce -> all outputs 0 during reset; after release btn_stable=4'hF exactly at release-edge 6, single change_irq pulse, btn_press=4'hF for one cycle.
REQ-024 sw_raw[3] toggling every 2 cycles for 40 cycles, then held 1 -> sw_stable[3] changes only once, at the 6th edge after the final hold begins.

Source files
------------

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - synchronize and debounce slide switches and push buttons
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sw_raw,
    input  logic [3:0]  btn_raw,
    input  logic [3:0]  evt_clr,
    output logic [15:0] sw_stable,
    output logic [3:0]  btn_stable,
    output logic [3:0]  btn_press,
    output logic [3:0]  btn_event,
    output logic        change_irq
);

    localparam int NUM_IN = 20;
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Switches occupy bits 15:0, buttons bits 19:16 of every per-input vector.
    logic [NUM_IN-1:0] raw;
    logic [NUM_IN-1:0] sync_meta;
    logic [NUM_IN-1:0] sync;
    logic [NUM_IN-1:0] stable;
    logic [NUM_IN-1:0] accept;
    logic [CW-1:0]     cnt [NUM_IN];
    logic [3:0]        btn_rise;

    assign raw        = {btn_raw, sw_raw};
    assign sw_stable  = stable[15:0];
    assign btn_stable = stable[19:16];

    // An input is accepted when it has disagreed with stable for the full count.
    always_comb begin
        accept = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            accept[i] = (sync[i] != stable[i]) && (cnt[i] == LAST);
        end
        btn_rise = accept[19:16] & ~stable[19:16];
    end

    // Two-flop synchronizer per input; only the second stage is used downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= raw;
            sync      <= sync_meta;
        end
    end

    // Per-input debounce counter: clears on agreement or acceptance, otherwise counts up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_IN; i++) begin
                cnt[i] <= '0;
            end
            stable <= '0;
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (sync[i] == stable[i] || accept[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
            stable <= stable ^ accept;
        end
    end

    // Press pulses, sticky events (set beats clear) and the change interrupt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_press  <= '0;
            btn_event  <= '0;
            change_irq <= 1'b0;
        end else begin
            btn_press  <= btn_rise;
            btn_event  <= (btn_event & ~evt_clr) | btn_press;
            change_irq <= (|accept[15:0]) | (|btn_rise);
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - directed self-checking bench for input_conditioner
module tb_input_conditioner;

    logic        clk;
    logic        rst;
    logic [15:0] sw_raw;
    logic [3:0]  btn_raw;
    logic [3:0]  evt_clr;
    logic [15:0] sw_stable;
    logic [3:0]  btn_stable;
    logic [3:0]  btn_press;
    logic [3:0]  btn_event;
    logic        change_irq;

    int checks;
    int errors;

    input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_raw     (sw_raw),
        .btn_raw    (btn_raw),
        .evt_clr    (evt_clr),
        .sw_stable  (sw_stable),
        .btn_stable (btn_stable),
        .btn_press  (btn_press),
        .btn_event  (btn_event),
        .change_irq (change_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        sw_raw  = 16'hFFFF;
        btn_raw = 4'hF;
        evt_clr = 4'h0;
        step();
        step();
        checks++;
        if (sw_stable !== 16'h0) begin errors++; $display("FAIL reset_sw: got %h want 0000", sw_stable); end
        checks++;
        if (btn_stable !== 4'h0) begin errors++; $display("FAIL reset_btn: got %h want 0", btn_stable); end
        checks++;
        if (btn_press !== 4'h0) begin errors++; $display("FAIL reset_press: got %h want 0", btn_press); end
        checks++;
        if (btn_event !== 4'h0) begin errors++; $display("FAIL reset_event: got %h want 0", btn_event); end
        checks++;
        if (change_irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", change_irq); end
        sw_raw  = 16'h0;
        btn_raw = 4'h0;
        step();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_sw_latency();
        sw_raw = 16'hA5A5;
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++;
            if (sw_stable !== 16'h0 || change_irq !== 1'b0) begin
                errors++;
                $display("FAIL sw_early edge %0d: sw %h irq %b want 0000 0", k, sw_stable, change_irq);
            end
        end
        step();
        checks++;
        if (sw_stable !== 16'hA5A5 || change_irq !== 1'b1) begin
            errors++;
            $display("FAIL sw_accept: sw %h irq %b want a5a5 1", sw_stable, change_irq);
        end
        step();
        checks++;
        if (sw_stable !== 16'hA5A5 || change_irq !== 1'b0) begin
            errors++;
            $display("FAIL sw_irq_end: sw %h irq %b want a5a5 0", sw_stable, change_irq);
        end
        sw_raw = 16'h0;
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++;
            if (sw_stable !== 16'hA5A5) begin
                errors++;
                $display("FAIL sw_fall_early edge %0d: got %h want a5a5", k, sw_stable);
            end
        end
        step();
        checks++;
        if (sw_stable !== 16'h0 || change_irq !== 1'b1 || btn_press !== 4'h0) begin
            errors++;
            $display("FAIL sw_fall: sw %h irq %b press %h want 0000 1 0", sw_stable, change_irq, btn_press);
        end
        step();
    endtask

    task automatic test_glitch();
        btn_raw = 4'b0100;
        step();
        step();
        step();
        btn_raw = 4'b0000;
        for (int k = 4; k <= 14; k++) begin
            step();
            checks++;
            if (btn_stable !== 4'h0 || btn_press !== 4'h0 || btn_event !== 4'h0 || change_irq !== 1'b0) begin
                errors++;
                $display("FAIL glitch edge %0d: stable %h press %h event %h irq %b want 0 0 0 0",
                         k, btn_stable, btn_press, btn_event, change_irq);
            end
        end
    endtask

    task automatic test_btn_press();
        btn_raw = 4'b0001;
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++;
            if (btn_stable !== 4'h0 || btn_press !== 4'h0) begin
                errors++;
                $display("FAIL btn_early edge %0d: stable %h press %h want 0 0", k, btn_stable, btn_press);
            end
        end
        step();
        checks++;
        if (btn_stable !== 4'h1 || btn_press !== 4'h1 || change_irq !== 1'b1 || btn_event !== 4'h0) begin
            errors++;
            $display("FAIL btn_accept: stable %h press %h irq %b event %h want 1 1 1 0",
                     btn_stable, btn_press, change_irq, btn_event);
        end
        step();
        checks++;
        if (btn_press !== 4'h0 || btn_event !== 4'h1 || change_irq !== 1'b0) begin
            errors++;
            $display("FAIL btn_after: press %h event %h irq %b want 0 1 0", btn_press, btn_event, change_irq);
        end
        btn_raw = 4'b0000;
        for (int k = 1; k <= 10; k++) begin
            step();
            checks++;
            if (btn_press !== 4'h0 || change_irq !== 1'b0 || btn_event !== 4'h1) begin
                errors++;
                $display("FAIL btn_release edge %0d: press %h irq %b event %h want 0 0 1",
                         k, btn_press, change_irq, btn_event);
            end
        end
        checks++;
        if (btn_stable !== 4'h0) begin errors++; $display("FAIL btn_released: got %h want 0", btn_stable); end
    endtask

    task automatic test_evt_clr();
        btn_raw = 4'b0010;
        for (int k = 1; k <= 7; k++) step();
        checks++;
        if (btn_event !== 4'b0011) begin errors++; $display("FAIL evt_first: got %b want 0011", btn_event); end
        btn_raw = 4'b0000;
        for (int k = 1; k <= 8; k++) step();
        btn_raw = 4'b0010;
        for (int k = 1; k <= 6; k++) step();
        checks++;
        if (btn_press !== 4'b0010) begin errors++; $display("FAIL evt_repress: got %b want 0010", btn_press); end
        evt_clr = 4'b0010;
        step();
        checks++;
        if (btn_event !== 4'b0011) begin errors++; $display("FAIL evt_set_wins: got %b want 0011", btn_event); end
        step();
        checks++;
        if (btn_event !== 4'b0001) begin errors++; $display("FAIL evt_clear: got %b want 0001", btn_event); end
        evt_clr = 4'b0001;
        step();
        checks++;
        if (btn_event !== 4'b0000) begin errors++; $display("FAIL evt_clear0: got %b want 0000", btn_event); end
        evt_clr = 4'b0000;
        btn_raw = 4'b0000;
        for (int k = 1; k <= 8; k++) step();
    endtask

    task automatic test_reset_mid();
        int irq_count;
        irq_count = 0;
        btn_raw = 4'hF;
        for (int k = 1; k <= 4; k++) step();
        rst = 1'b1;
        #1;
        checks++;
        if (btn_stable !== 4'h0 || btn_press !== 4'h0 || btn_event !== 4'h0 || change_irq !== 1'b0 || sw_stable !== 16'h0) begin
            errors++;
            $display("FAIL rst_async: stable %h press %h event %h irq %b sw %h want all 0",
                     btn_stable, btn_press, btn_event, change_irq, sw_stable);
        end
        step();
        step();
        checks++;
        if (btn_stable !== 4'h0 || btn_press !== 4'h0 || change_irq !== 1'b0) begin
            errors++;
            $display("FAIL rst_held: stable %h press %h irq %b want 0 0 0", btn_stable, btn_press, change_irq);
        end
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (change_irq === 1'b1) irq_count++;
            checks++;
            if (btn_stable !== 4'h0) begin
                errors++;
                $display("FAIL rst_stale edge %0d: got %h want 0", k, btn_stable);
            end
        end
        step();
        if (change_irq === 1'b1) irq_count++;
        checks++;
        if (btn_stable !== 4'hF || btn_press !== 4'hF) begin
            errors++;
            $display("FAIL rst_accept: stable %h press %h want f f", btn_stable, btn_press);
        end
        for (int k = 7; k <= 10; k++) begin
            step();
            if (change_irq === 1'b1) irq_count++;
            checks++;
            if (btn_press !== 4'h0) begin
                errors++;
                $display("FAIL rst_press_len edge %0d: got %h want 0", k, btn_press);
            end
        end
        checks++;
        if (irq_count != 1) begin errors++; $display("FAIL rst_irq_count: got %0d want 1", irq_count); end
        checks++;
        if (btn_event !== 4'hF) begin errors++; $display("FAIL rst_event: got %h want f", btn_event); end
        btn_raw = 4'h0;
        evt_clr = 4'hF;
        for (int k = 1; k <= 8; k++) step();
        evt_clr = 4'h0;
    endtask

    task automatic test_toggle();
        for (int p = 0; p < 10; p++) begin
            for (int h = 0; h < 4; h++) begin
                sw_raw = (h < 2) ? 16'h0008 : 16'h0000;
                step();
                checks++;
                if (sw_stable !== 16'h0 || change_irq !== 1'b0) begin
                    errors++;
                    $display("FAIL toggle period %0d phase %0d: sw %h irq %b want 0000 0", p, h, sw_stable, change_irq);
                end
            end
        end
        sw_raw = 16'h0008;
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++;
            if (sw_stable !== 16'h0) begin
                errors++;
                $display("FAIL hold_early edge %0d: got %h want 0000", k, sw_stable);
            end
        end
        step();
        checks++;
        if (sw_stable !== 16'h0008 || change_irq !== 1'b1) begin
            errors++;
            $display("FAIL hold_accept: sw %h irq %b want 0008 1", sw_stable, change_irq);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        sw_raw = '0;
        btn_raw = '0;
        evt_clr = '0;
        test_reset();
        test_sw_latency();
        test_glitch();
        test_btn_press();
        test_evt_clr();
        test_reset_mid();
        test_toggle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
